// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file with two combinational read ports and one clocked write port.
// Register 0 always reads zero. Registers 2 and 3 ($v0/$v1) are also driven out as dedicated result outputs.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] V0,
  output logic [DATA_WIDTH-1:0] V1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_en;

  // Address 0 is never written, so regs[0] stays at its reset value of zero.
  assign write_en = RegWrite && (WriteRegister != '0);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Reads have no write-through bypass: a same-cycle write becomes visible only after the edge.
  assign ReadData1 = (ReadRegister1 == '0) ? '0 : regs[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == '0) ? '0 : regs[ReadRegister2];
  assign V0        = regs[2];
  assign V1        = regs[3];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, register 0, enable gating, read-during-write timing,
// $v0/$v1 outputs and asynchronous reset in the middle of a cycle.
module tb_register_file;

  logic        Clock;
  logic        ResetN;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] V0;
  logic [31:0] V1;

  int errors = 0;
  int checks = 0;
  logic [31:0] prior [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .RegWrite(RegWrite),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .V0(V0),
    .V1(V1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Sets up the write on a falling edge so it is captured by the following rising edge.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge Clock);
    WriteRegister = addr;
    WriteData     = data;
    RegWrite      = 1'b1;
    @(negedge Clock);
    RegWrite      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = a[4:0];
      ReadRegister2 = 5'(31 - a);
      #0.1;
      check({tag, "_rd1"}, ReadData1, 32'h0);
      check({tag, "_rd2"}, ReadData2, 32'h0);
    end
    check({tag, "_v0"}, V0, 32'h0);
    check({tag, "_v1"}, V1, 32'h0);
  endtask

  initial begin
    ResetN        = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Reset state, then random prior contents and a reset pulse.
    #12;
    check_all_zero("por");
    @(negedge Clock);
    ResetN = 1'b1;
    for (int a = 1; a < 32; a++) begin
      prior[a] = $urandom;
      write_reg(a[4:0], prior[a]);
    end
    ReadRegister1 = 5'd17;
    ReadRegister2 = 5'd31;
    #1;
    check("prior_r17", ReadData1, prior[17]);
    check("prior_r31", ReadData2, prior[31]);
    check("prior_v0", V0, prior[2]);
    @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check_all_zero("pulse");
    @(negedge Clock);
    ResetN = 1'b1;
    #1;
    check_all_zero("post_rel");

    // Basic write/read.
    write_reg(5'd5, 32'hDEADBEEF);
    ReadRegister1 = 5'd5;
    #1;
    check("r5", ReadData1, 32'hDEADBEEF);
    write_reg(5'd10, 32'hCAFEBABE);
    ReadRegister2 = 5'd10;
    #1;
    check("r10", ReadData2, 32'hCAFEBABE);
    check("r5_keep", ReadData1, 32'hDEADBEEF);
    ReadRegister2 = 5'd5;
    #1;
    check("same_addr_rd1", ReadData1, 32'hDEADBEEF);
    check("same_addr_rd2", ReadData2, 32'hDEADBEEF);

    // Register 0 discards writes.
    write_reg(5'd0, 32'hFFFFFFFF);
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #1;
    check("r0_rd1", ReadData1, 32'h0);
    check("r0_rd2", ReadData2, 32'h0);

    // Enable gating: reg 7 holds while RegWrite is low.
    write_reg(5'd7, 32'h0BADF00D);
    @(negedge Clock);
    RegWrite      = 1'b0;
    WriteRegister = 5'd7;
    WriteData     = 32'h12345678;
    ReadRegister1 = 5'd7;
    repeat (3) @(negedge Clock);
    check("r7_gated", ReadData1, 32'h0BADF00D);

    // Read-during-write: old value before the edge, new value after it.
    RegWrite = 1'b1;
    #1;
    check("rdw_before", ReadData1, 32'h0BADF00D);
    @(posedge Clock);
    #1;
    check("rdw_after", ReadData1, 32'h12345678);
    RegWrite = 1'b0;

    // $v0/$v1 follow writes right after the edge.
    @(negedge Clock);
    WriteRegister = 5'd2;
    WriteData     = 32'h00000011;
    RegWrite      = 1'b1;
    @(posedge Clock);
    #1;
    check("v0", V0, 32'h00000011);
    @(negedge Clock);
    WriteRegister = 5'd3;
    WriteData     = 32'h00000022;
    @(posedge Clock);
    #1;
    check("v1", V1, 32'h00000022);
    check("v0_keep", V0, 32'h00000011);
    @(negedge Clock);
    RegWrite = 1'b0;

    // Async reset mid-cycle after filling regs 1..31 with their index.
    for (int a = 1; a < 32; a++) write_reg(a[4:0], 32'(a));
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd31;
    #1;
    check("fill_r9", ReadData1, 32'd9);
    check("fill_r31", ReadData2, 32'd31);
    check("fill_v0", V0, 32'd2);
    check("fill_v1", V1, 32'd3);
    @(negedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    check("mid_rd1", ReadData1, 32'h0);
    check("mid_rd2", ReadData2, 32'h0);
    check("mid_v0", V0, 32'h0);
    check("mid_v1", V1, 32'h0);
    WriteRegister = 5'd9;
    WriteData     = 32'hAAAA5555;
    RegWrite      = 1'b1;
    @(posedge Clock);
    #1;
    check("rst_write_rd1", ReadData1, 32'h0);
    @(negedge Clock);
    RegWrite = 1'b0;
    ResetN   = 1'b1;
    #1;
    check("rst_write_lost", ReadData1, 32'h0);
    check_all_zero("mid_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
